sdram_burst_arbiter: RTL
========================

# sdram_burst_arbiter

Burst scheduler for the four-port SDRAM frame-buffer controller. It watches the fill levels of the two read-side and two write-side port FIFOs and picks which port gets the next SDRAM page burst. It presents one grant at a time to the burst engine and holds it until the engine reports completion. It replaces the fixed-priority selection with optional aging, so a continuously hungry read port cannot starve a write port.

## Interface
Parameters:
- LEN_W, 9: burst length width.
- USE_W, 16: FIFO used-word width.
- AGE_MAX, 15: age count at which a waiting port becomes urgent; range 1..255.
- GAP_CYC, 2: idle cycles after each burst so dual-clock FIFO levels can settle; range 1..7.

Ports:
- CLK, in, 1: controller clock.
- RESET_N, in, 1: reset, asynchronous, active-low.
- RD_LEVEL, in, 2*USE_W: write-side used words of read FIFOs; port 0 in the low slice.
- RD_LENGTH, in, 2*LEN_W: burst length per read port.
- WR_LEVEL, in, 2*USE_W: read-side used words of write FIFOs.
- WR_LENGTH, in, 2*LEN_W: burst length per write port.
- LOAD, in, 4: per-port load/clear, order {WR1,WR0,RD1,RD0}.
- BURST_DONE, in, 1: one-cycle pulse from the engine when the granted burst finishes.
- BURST_REQ, out, 1: grant valid.
- GRANT, out, 4: one-hot port, same order as LOAD.
- GRANT_LEN, out, LEN_W: length of the granted port, captured at grant time.
- GRANT_RD, out, 1: 1 means read burst, 0 means write burst.
- ERR_SPURIOUS, out, 1: sticky flag, set when BURST_DONE arrives outside WAIT.

## Operation
- Eligibility, evaluated combinationally each cycle:
  - Read port i is eligible when RD_LENGTH[i]!=0, RD_LEVEL[i] < RD_LENGTH[i] and LOAD[i]=0.
  - Write port j is eligible when WR_LENGTH[j]!=0, WR_LEVEL[j] >= WR_LENGTH[j] and LOAD[j+2]=0.
  - Compares are unsigned. LEN_W is zero-extended to USE_W.
- Any LOAD bit high blocks every new grant, matching the controller's global quiesce.
- Base priority: RD0 > RD1 > WR0 > WR1.
- State machine:
  - IDLE: if any port is eligible and no LOAD is high, go to GRANT.
  - GRANT (1 cycle): register the winner into GRANT, GRANT_LEN and GRANT_RD; set BURST_REQ=1; go to WAIT.
  - WAIT: hold all grant outputs stable. On BURST_DONE, clear BURST_REQ and GRANT in the same edge and go to GAP.
  - GAP: count GAP_CYC cycles, then go to IDLE.
- LOAD asserted during WAIT does not abort the burst. The grant is held until BURST_DONE.
- A BURST_DONE seen in IDLE, GRANT or GAP is ignored and sets ERR_SPURIOUS.

## Timing
- Reset values: BURST_REQ=0, GRANT=0, GRANT_LEN=0, GRANT_RD=0, ERR_SPURIOUS=0, every age counter 0, state IDLE.
- Latency: eligibility true in IDLE at edge n, then BURST_REQ=1 at edge n+2 (IDLE->GRANT at n+1, outputs registered at n+2).
- Handshake: the engine samples the grant on the rising edge of BURST_REQ. BURST_REQ deasserts the cycle after BURST_DONE is sampled.
- Next grant: no earlier than GAP_CYC+2 cycles after BURST_DONE.
- Back-to-back bursts for the same port are legal when it is still the winner.
- Reset asserted mid-burst returns all outputs to their reset values immediately (asynchronous). The engine is reset by the same RESET_N.

## Configuration
- ARB_AGING_EN defined:
  - Each port has an 8-bit saturating age counter.
  - In the GRANT cycle, every eligible port that was not chosen increments by 1, saturating at AGE_MAX.
  - The chosen port's counter clears to 0, as does any counter whose port is ineligible in that cycle.
  - A port with age == AGE_MAX is urgent. Urgent ports beat non-urgent ports; ties among urgent ports use base priority.
- ARB_AGING_EN undefined: counters are absent and pure base priority applies.

## Test plan
- Reset check: RESET_N low, then all outputs 0. Release with RD_LEVEL0=0, RD_LENGTH0=256 -> BURST_REQ=1 two cycles later, GRANT=4'b0001, GRANT_LEN=256, GRANT_RD=1.
- Write eligibility boundary: WR_LENGTH0=256, WR_LEVEL0=255 -> no grant. Set WR_LEVEL0=256 -> GRANT=4'b0100, GRANT_RD=0.
- Zero-length and LOAD blocking: RD_LENGTH1=0 with RD_LEVEL1=0 -> RD1 never granted. LOAD[3]=1 with all ports eligible -> no new grant. Pulse LOAD during WAIT -> grant stays held until BURST_DONE.
- Aging (ARB_AGING_EN, AGE_MAX=3): RD0 and WR1 permanently eligible, BURST_DONE issued 4 cycles after each grant -> grant sequence RD0,RD0,RD0,WR1,RD0. Without the macro -> RD0 forever.
- Gap and spurious done (GAP_CYC=2): after BURST_DONE, next BURST_REQ rises exactly 4 cycles later. BURST_DONE pulsed in IDLE -> ERR_SPURIOUS=1, and it stays 1 until reset.

Source files
------------

// File: rtl/sdram_burst_arbiter.sv
// Burst scheduler for the four-port SDRAM frame buffer: picks one read/write port per page burst.
// Optional aging (define ARB_AGING_EN) makes long-waiting ports urgent so no port can starve.
module sdram_burst_arbiter #(
   parameter int LEN_W   = 9,
   parameter int USE_W   = 16,
   parameter int AGE_MAX = 15,
   parameter int GAP_CYC = 2
) (
   input  logic               CLK,
   input  logic               RESET_N,
   input  logic [2*USE_W-1:0] RD_LEVEL,
   input  logic [2*LEN_W-1:0] RD_LENGTH,
   input  logic [2*USE_W-1:0] WR_LEVEL,
   input  logic [2*LEN_W-1:0] WR_LENGTH,
   input  logic [3:0]         LOAD,
   input  logic               BURST_DONE,
   output logic               BURST_REQ,
   output logic [3:0]         GRANT,
   output logic [LEN_W-1:0]   GRANT_LEN,
   output logic               GRANT_RD,
   output logic               ERR_SPURIOUS
);

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT, S_GAP} state_t;

   localparam int CMP_W = (USE_W > LEN_W) ? USE_W : LEN_W;

   state_t                    state_q, state_d;
   logic [2:0]                gap_cnt_q, gap_cnt_d;
   logic                      req_q, req_d;
   logic [3:0]                grant_q, grant_d;
   logic [LEN_W-1:0]          len_q, len_d;
   logic                      rd_q, rd_d;
   logic                      err_q, err_d;
   logic [3:0]                elig;
   logic [3:0]                winner;
   logic [LEN_W-1:0]          win_len;
   logic [3:0][LEN_W-1:0]     len_all;

   assign len_all = {WR_LENGTH, RD_LENGTH};

   for (genvar i = 0; i < 2; i++) begin : g_elig
      logic [CMP_W-1:0] rd_len, rd_lvl, wr_len, wr_lvl;
      assign rd_len = CMP_W'(RD_LENGTH[i*LEN_W +: LEN_W]);
      assign rd_lvl = CMP_W'(RD_LEVEL[i*USE_W +: USE_W]);
      assign wr_len = CMP_W'(WR_LENGTH[i*LEN_W +: LEN_W]);
      assign wr_lvl = CMP_W'(WR_LEVEL[i*USE_W +: USE_W]);
      // Reads need room for a whole burst; writes need a whole burst already buffered.
      assign elig[i]   = (rd_len != '0) && (rd_lvl <  rd_len) && !LOAD[i];
      assign elig[i+2] = (wr_len != '0) && (wr_lvl >= wr_len) && !LOAD[i+2];
   end

   // Lowest set bit wins, which encodes RD0 > RD1 > WR0 > WR1.
   function automatic logic [3:0] pick_first(input logic [3:0] v);
      pick_first = v & (~v + 4'd1);
   endfunction

`ifdef ARB_AGING_EN
   logic [3:0][7:0] age_q, age_d;
   logic [3:0]      urgent;

   for (genvar i = 0; i < 4; i++) begin : g_urgent
      assign urgent[i] = elig[i] && (age_q[i] == 8'(AGE_MAX));
   end

   assign winner = (|urgent) ? pick_first(urgent) : pick_first(elig);
`else
   assign winner = pick_first(elig);
`endif

   always_comb begin
      win_len = '0;
      for (int i = 0; i < 4; i++) begin
         if (winner[i]) win_len = len_all[i];
      end
   end

   always_comb begin
      // NOTE: every variable gets its hold value first so no path infers a latch.
      state_d   = state_q;
      gap_cnt_d = gap_cnt_q;
      req_d     = req_q;
      grant_d   = grant_q;
      len_d     = len_q;
      rd_d      = rd_q;
      err_d     = err_q | (BURST_DONE && (state_q != S_WAIT));
`ifdef ARB_AGING_EN
      age_d     = age_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if ((|elig) && !(|LOAD)) state_d = S_GRANT;
         end
         S_GRANT: begin
            if ((|winner) && !(|LOAD)) begin
               req_d   = 1'b1;
               grant_d = winner;
               len_d   = win_len;
               rd_d    = |winner[1:0];
               state_d = S_WAIT;
`ifdef ARB_AGING_EN
               for (int i = 0; i < 4; i++) begin
                  if (winner[i] || !elig[i])     age_d[i] = 8'd0;
                  else if (age_q[i] < 8'(AGE_MAX)) age_d[i] = age_q[i] + 8'd1;
               end
`endif
            end else begin
               // Eligibility vanished or a LOAD arrived since IDLE: back off.
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (BURST_DONE) begin
               req_d     = 1'b0;
               grant_d   = 4'b0000;
               gap_cnt_d = 3'd0;
               state_d   = S_GAP;
            end
         end
         S_GAP: begin
            if (gap_cnt_q == 3'(GAP_CYC - 1)) state_d = S_IDLE;
            else                              gap_cnt_d = gap_cnt_q + 3'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignment so all flops update together.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= S_IDLE;
         gap_cnt_q <= 3'd0;
         req_q     <= 1'b0;
         grant_q   <= 4'b0000;
         len_q     <= '0;
         rd_q      <= 1'b0;
         err_q     <= 1'b0;
`ifdef ARB_AGING_EN
         age_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         gap_cnt_q <= gap_cnt_d;
         req_q     <= req_d;
         grant_q   <= grant_d;
         len_q     <= len_d;
         rd_q      <= rd_d;
         err_q     <= err_d;
`ifdef ARB_AGING_EN
         age_q     <= age_d;
`endif
      end
   end

   assign BURST_REQ    = req_q;
   assign GRANT        = grant_q;
   assign GRANT_LEN    = len_q;
   assign GRANT_RD     = rd_q;
   assign ERR_SPURIOUS = err_q;

endmodule
